// File: rtl/seq_detect_scheduler_pkg.sv
// seq_det_pkg
//   Shared defaults and the default-geometry channel context layout for the
//   time-multiplexed sequence detector.
//   Contents:
//     NCH_DEF, PLEN_DEF, PAT_1011, CNTW_DEF  default build parameters
//     ctx_t                                  {hist, fill, cnt} at default sizes
package seq_det_pkg;

    localparam int         NCH_DEF  = 4;
    localparam int         PLEN_DEF = 4;
    localparam logic [3:0] PAT_1011 = 4'b1011;
    localparam int         CNTW_DEF = 8;

    // hist keeps the PLEN-1 most recent bits (LSB newest), fill counts the
    // bits seen up to PLEN-1, cnt is the saturating hit counter.
    typedef struct packed {
        logic [PLEN_DEF-2:0]         hist;
        logic [$clog2(PLEN_DEF)-1:0] fill;
        logic [CNTW_DEF-1:0]         cnt;
    } ctx_t;

endpackage

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with a rotating priority pointer. The request at
//   rr_ptr has highest priority, then rr_ptr+1, ... (mod N). After a granted
//   transfer the pointer moves to one past the granted index; otherwise it holds.
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset (rr_ptr -> 0)
//     req      per-requester request vector
//     grant    one-hot grant, combinational from req and rr_ptr
//     advance  strobe: the current grant was consumed this cycle
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    input  logic         advance
);

    logic [W-1:0] rr_ptr;
    logic [W-1:0] gidx;
    logic [W-1:0] idx;

    // Scan from the lowest-priority offset down so the highest-priority
    // requester is the last one written and wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(rr_ptr) + i) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (gidx == W'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
//   One overlapping Mealy pattern detector shared by NCH single-bit streams.
//   A round-robin arbiter accepts at most one bit per cycle; the granted
//   channel's context (history, fill level, hit count) is read, updated and
//   written back, so every channel behaves as an independent detector.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     ch_en        per-channel enable (disabled channels keep their context)
//     in_valid     per-channel bit present
//     in_bit       per-channel bit value
//     in_ready     one-hot combinational grant; transfer = in_valid & in_ready
//     clr          synchronous clear of all contexts (no transfer that cycle)
//     match_valid  registered pulse: previous transfer completed PATTERN
//     match_ch     channel of the last match (holds between matches)
//     rd_ch        hit-count readout select
//     rd_cnt       hit count of channel rd_ch
module seq_detect_scheduler
    import seq_det_pkg::*;
#(
    parameter  int              NCH     = NCH_DEF,
    parameter  int              PLEN    = PLEN_DEF,
    parameter  logic [PLEN-1:0] PATTERN = PAT_1011,
    parameter  int              CNTW    = CNTW_DEF,
    localparam int              CHW     = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  ch_en,
    input  logic [NCH-1:0]  in_valid,
    input  logic [NCH-1:0]  in_bit,
    output logic [NCH-1:0]  in_ready,
    input  logic            clr,
    output logic            match_valid,
    output logic [CHW-1:0]  match_ch,
    input  logic [CHW-1:0]  rd_ch,
    output logic [CNTW-1:0] rd_cnt
);

    localparam int               HW        = PLEN - 1;
    localparam int               FILLW     = $clog2(PLEN);
    localparam logic [FILLW-1:0] FILL_FULL = FILLW'(PLEN - 1);

    typedef struct packed {
        logic [HW-1:0]    hist;
        logic [FILLW-1:0] fill;
        logic [CNTW-1:0]  cnt;
    } chan_ctx_t;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Append the new bit and drop the oldest; written as a truncating cast so
    // it also covers PLEN = 2 (single-bit history).
    function automatic logic [HW-1:0] shift_in(input logic [HW-1:0] h, input logic b);
        return HW'({h, b});
    endfunction

    chan_ctx_t      ctx [NCH];
    logic [NCH-1:0] req;
    logic [NCH-1:0] grant;
    logic           xfer;
    logic [CHW-1:0] g;
    logic           b;
    logic           hit;
    chan_ctx_t      cur;

    // Arbitration: nothing is offered during reset or a clear cycle.
    assign req = in_valid & ch_en & {NCH{rst_n & ~clr}};

    rr_arbiter #(.N(NCH)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .grant   (grant),
        .advance (xfer)
    );

    assign in_ready = grant;
    assign xfer     = |grant;

    always_comb begin
        g = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) g = CHW'(i);
        end
    end

    // Match evaluation on the restored context of the granted channel.
    assign cur = ctx[g];
    assign b   = in_bit[g];
    assign hit = xfer && (cur.fill == FILL_FULL) && ({cur.hist, b} == PATTERN);

    // Context write-back and registered match report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) ctx[i] <= '0;
            match_valid <= 1'b0;
            match_ch    <= '0;
        end else if (clr) begin
            for (int i = 0; i < NCH; i++) ctx[i] <= '0;
            match_valid <= 1'b0;
        end else begin
            match_valid <= hit;
            if (hit) match_ch <= g;
            if (xfer) begin
                ctx[g].hist <= shift_in(cur.hist, b);
                if (cur.fill != FILL_FULL) ctx[g].fill <= cur.fill + 1'b1;
                if (hit) ctx[g].cnt <= sat_inc(cur.cnt);
            end
        end
    end

    assign rd_cnt = (int'(rd_ch) < NCH) ? ctx[rd_ch].cnt : '0;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb_seq_detect_scheduler
//   Directed bench for seq_detect_scheduler. Two instances share every input:
//   the default build and a CNTW=2 build whose counter saturates at 3.
module tb_seq_detect_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ch_en, in_valid, in_bit;
    logic       clr;
    logic [1:0] rd_ch;
    logic [3:0] in_ready, in_ready_s;
    logic       mv, mv_s;
    logic [1:0] mc, mc_s;
    logic [7:0] cnt;
    logic [1:0] cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detect_scheduler dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .in_valid(in_valid),
        .in_bit(in_bit), .in_ready(in_ready), .clr(clr),
        .match_valid(mv), .match_ch(mc), .rd_ch(rd_ch), .rd_cnt(cnt)
    );

    seq_detect_scheduler #(.CNTW(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .in_valid(in_valid),
        .in_bit(in_bit), .in_ready(in_ready_s), .clr(clr),
        .match_valid(mv_s), .match_ch(mc_s), .rd_ch(rd_ch), .rd_cnt(cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, check the grant, then check the
    // registered match report just after the rising edge.
    task automatic cyc(input logic [3:0] v, input logic [3:0] e, input logic [3:0] bits,
                       input logic [3:0] exp_rdy, input logic exp_mv,
                       input logic [1:0] exp_mc, input string tag);
        @(negedge clk);
        in_valid = v;
        ch_en    = e;
        in_bit   = bits;
        #1;
        check({tag, ".rdy"}, 32'(in_ready), 32'(exp_rdy));
        check({tag, ".rdy_s"}, 32'(in_ready_s), 32'(exp_rdy));
        @(posedge clk);
        #1;
        check({tag, ".mv"}, 32'(mv), 32'(exp_mv));
        check({tag, ".mv_s"}, 32'(mv_s), 32'(exp_mv));
        if (exp_mv) begin
            check({tag, ".mc"}, 32'(mc), 32'(exp_mc));
            check({tag, ".mc_s"}, 32'(mc_s), 32'(exp_mc));
        end
    endtask

    task automatic feed0(input logic bv, input logic exp_mv, input string tag);
        cyc(4'b0001, 4'hF, {3'b000, bv}, 4'b0001, exp_mv, 2'd0, tag);
    endtask

    task automatic rd_check(input logic [1:0] ch, input logic [7:0] exp,
                            input logic [1:0] exp_s, input string tag);
        rd_ch = ch;
        #1;
        check({tag, ".cnt"}, 32'(cnt), 32'(exp));
        check({tag, ".cnt_s"}, 32'(cnt_s), 32'(exp_s));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = '0;
        clr      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] s0, s1, pat;
        logic [4:0] s4;
        logic [6:0] s7;
        int         hits;

        rst_n    = 1'b0;
        clr      = 1'b0;
        ch_en    = 4'hF;
        in_valid = 4'hF;
        in_bit   = 4'hF;
        rd_ch    = 2'd0;

        // Reset state, including in_ready forced low while requests are up.
        @(posedge clk);
        #1;
        check("rst.rdy", 32'(in_ready), 32'h0);
        check("rst.mv", 32'(mv), 32'h0);
        check("rst.mc", 32'(mc), 32'h0);
        check("rst.cnt", 32'(cnt), 32'h0);
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;

        // 1: ch0 alone, 1011011 -> hits on transfers 4 and 7 (overlap).
        s7 = 7'b1011011;
        for (int i = 0; i < 7; i++)
            feed0(s7[6-i], (i == 3) || (i == 6), $sformatf("t1.%0d", i));
        rd_check(2'd0, 8'd2, 2'd2, "t1");

        do_reset();
        rd_check(2'd0, 8'd0, 2'd0, "t1.rst");

        // 2: ch0 and ch1 always valid; grants alternate 0,1; only ch0 matches.
        s0 = 4'b1011;
        s1 = 4'b1111;
        for (int c = 0; c < 8; c++)
            cyc(4'b0011, 4'hF, {2'b00, s1[3-c/2], s0[3-c/2]},
                (c % 2 == 0) ? 4'b0001 : 4'b0010, (c == 6), 2'd0,
                $sformatf("t2.%0d", c));
        rd_check(2'd0, 8'd1, 2'd1, "t2.ch0");
        rd_check(2'd1, 8'd0, 2'd0, "t2.ch1");

        // 3: last grant was ch1, so the pointer sits at 2: order 2,3,0,1,...
        for (int c = 0; c < 8; c++)
            cyc(4'b1111, 4'hF, 4'b0000, 4'(1 << ((2 + c) % 4)), 1'b0, 2'd0,
                $sformatf("t3.%0d", c));

        // 4: ch0 gets 101, is disabled while ch1 runs 10110, then resumes.
        do_reset();
        feed0(1'b1, 1'b0, "t4.a");
        feed0(1'b0, 1'b0, "t4.b");
        feed0(1'b1, 1'b0, "t4.c");
        s4 = 5'b10110;
        for (int c = 0; c < 5; c++)
            cyc(4'b0011, 4'b1110, {2'b00, s4[4-c], 1'b1}, 4'b0010, (c == 3), 2'd1,
                $sformatf("t4.dis%0d", c));
        check("t4.hold_mc", 32'(mc), 32'd1);
        cyc(4'b0001, 4'hF, 4'b0001, 4'b0001, 1'b1, 2'd0, "t4.resume");
        rd_check(2'd0, 8'd1, 2'd1, "t4.ch0");
        rd_check(2'd1, 8'd1, 2'd1, "t4.ch1");

        // 5: 1011 five times on ch0; the 2-bit counter stops at 3.
        do_reset();
        pat  = 4'b1011;
        hits = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++)
                feed0(pat[3-k], (k == 3), $sformatf("t5.%0d.%0d", r, k));
            hits++;
            if (hits == 3) rd_check(2'd0, 8'd3, 2'd3, "t5.third");
        end
        rd_check(2'd0, 8'd5, 2'd3, "t5.end");

        // 6a: 101, then clr with a pending 1: no transfer, contexts wiped.
        feed0(1'b1, 1'b0, "t6.a");
        feed0(1'b0, 1'b0, "t6.b");
        feed0(1'b1, 1'b0, "t6.c");
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 4'b0001;
        in_bit   = 4'b0001;
        #1;
        check("t6.clr_rdy", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        check("t6.clr_mv", 32'(mv), 32'h0);
        rd_check(2'd0, 8'd0, 2'd0, "t6.clr");
        @(negedge clk);
        clr      = 1'b0;
        in_valid = '0;
        feed0(1'b1, 1'b0, "t6.after");
        feed0(1'b1, 1'b0, "t6.f0");
        feed0(1'b0, 1'b0, "t6.f1");
        feed0(1'b1, 1'b0, "t6.f2");
        feed0(1'b1, 1'b1, "t6.f3");
        rd_check(2'd0, 8'd1, 2'd1, "t6.cnt");

        // 6b: async reset mid-cycle after 101; the following 1 cannot match.
        feed0(1'b1, 1'b0, "t6.g0");
        feed0(1'b0, 1'b0, "t6.g1");
        feed0(1'b1, 1'b0, "t6.g2");
        #2;
        rst_n    = 1'b0;
        in_valid = 4'b0001;
        #1;
        check("t6.arst_rdy", 32'(in_ready), 32'h0);
        check("t6.arst_mv", 32'(mv), 32'h0);
        rd_check(2'd0, 8'd0, 2'd0, "t6.arst");
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        feed0(1'b1, 1'b0, "t6.h0");
        feed0(1'b0, 1'b0, "t6.h1");
        feed0(1'b1, 1'b0, "t6.h2");
        feed0(1'b1, 1'b1, "t6.h3");

        @(negedge clk);
        in_valid = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
- Shares one serial pattern-match engine among NCH independent single-bit input streams.
- A round-robin arbiter accepts at most one bit per cycle. Per-channel context (bit history, fill level, hit count) is saved and restored, so each channel behaves as its own overlapping Mealy detector.
- Sits between the serial front-ends and the event/statistics logic, replacing one detector instance per channel.

Parameters:
- NCH, 4, number of input channels (≥2).
- PLEN, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, pattern to detect. MSB is the oldest bit; overlapping matches count.
- CNTW, 8, per-channel hit-counter width.
- CHW, $clog2(NCH), channel-index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ch_en  input  NCH  per-channel enable; a disabled channel is never granted.
- in_valid  input  NCH  channel i presents a bit.
- in_bit  input  NCH  bit value for channel i.
- in_ready  output  NCH  one-hot grant (combinational); a transfer occurs when in_valid[i] & in_ready[i].
- clr  input  1  synchronous clear of all channel contexts.
- match_valid  output  1  registered pulse: the previous transfer completed PATTERN.
- match_ch  output  CHW  channel of that match; holds its last value when match_valid=0.
- rd_ch  input  CHW  hit-count readout select.
- rd_cnt  output  CNTW  hit count of channel rd_ch (combinational read of the counter register).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all hist, fill, cnt = 0; rr_ptr = 0; match_valid = 0; match_ch = 0. in_ready = 0 while rst_n = 0.
- Arbitration: req = in_valid & ch_en. Grant goes to the first set req bit scanning rr_ptr, rr_ptr+1, … mod NCH. in_ready = one-hot grant, or all-zero if req = 0 or clr = 1. in_ready may depend combinationally on in_valid; in_valid must not depend on in_ready.
- Pointer update: after a transfer on channel g, rr_ptr <= (g+1) mod NCH. With no transfer, rr_ptr holds. Under continuous requests from k channels, each is served once every k cycles.
- Context update on a transfer of bit b on channel g:
  - hist[g] (PLEN-1 bits) <= {hist[g][PLEN-3:0], b}.
  - fill[g] <= min(fill[g]+1, PLEN-1).
  - hit = (fill[g] == PLEN-1) && ({hist[g], b} == PATTERN).
- Fill gating: no match is possible before PLEN bits have arrived on that channel, even if PATTERN has leading zeros.
- On hit:
  - match_valid <= 1 and match_ch <= g in the next cycle (latency 1 from the accepting edge).
  - cnt[g] <= cnt[g]+1, saturating at 2^CNTW-1.
- Without a hit, match_valid <= 0.
- Overlap: history is never flushed on a match. With 1011, the stream 1011011 yields 2 hits.
- Disable: clearing ch_en[i] blocks grants to channel i but retains its hist, fill and cnt. Re-enabling resumes the sequence exactly where it stopped.
- clr = 1: all hist, fill, cnt <= 0 and match_valid <= 0 at the next edge; no transfer is accepted that cycle; rr_ptr holds.
- Async reset mid-stream: all contexts are lost immediately; the first PLEN-1 bits after release cannot produce a match.

Decomposition:
- Package seq_det_pkg holds:
  - defaults NCH_DEF = 4, PLEN_DEF = 4, PAT_1011 = 4'b1011, CNTW_DEF = 8;
  - a channel-context struct typedef {hist, fill, cnt}.
- Sub-module rr_arbiter (parameter N): ports req, grant (one-hot), advance (transfer strobe), clk, rst_n. It owns rr_ptr.
- The top level holds the context arrays, match logic and readout mux.

Test Plan:
1. ch0 only, bits 1,0,1,1,0,1,1 on consecutive cycles -> match_valid pulses (match_ch=0) one cycle after the 4th and 7th transfers; rd_ch=0 gives rd_cnt=2.
2. ch0 and ch1 both valid every cycle, ch0 fed 1,0,1,1 and ch1 fed 1,1,1,1 -> grants alternate 0,1,0,1,…; exactly one match (ch0); rd_cnt(ch1)=0, showing no cross-channel history leakage.
3. All four channels valid continuously, starting with rr_ptr=2 -> grant order 2,3,0,1,2…; each channel gets exactly one grant per 4 cycles.
4. ch0 fed 1,0,1, then ch_en[0]=0 for 5 cycles while ch1 runs; re-enable and feed 1 -> ch0 match; while disabled, in_ready[0]=0 even with in_valid[0]=1.
5. CNTW=2 build, ch0 fed 1011 repeated 5 times (overlapping) -> rd_cnt holds at 3 after the 3rd hit; match_valid still pulses every hit.
6. ch0 fed 1,0,1, then clr (or rst_n low) for one cycle, then 1 -> no match; a fresh 1,0,1,1 then matches; in_ready=0 during the clr cycle.
